// File: rtl/frame_mem_arbiter_if.sv
// Requester and memory-side signal bundle for frame_mem_arbiter.
// slave = arbiter side; master = requesters plus memory model.
interface frame_mem_arbiter_if #(
   parameter int AW = 16,
   parameter int DW = 24
);
   logic [2:0]      req;
   logic [14:0]     len;
   logic [3*AW-1:0] addr;
   logic [2:0]      wr;
   logic [3*DW-1:0] wdata;
   logic [2:0]      gnt;
   logic [2:0]      beat;
   logic [2:0]      rvalid;
   logic [DW-1:0]   rdata;
   logic            mem_en;
   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [DW-1:0]   mem_rdata;

   modport slave (
      input  req, len, addr, wr, wdata, mem_rdata,
      output gnt, beat, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req, len, addr, wr, wdata, mem_rdata,
      input  gnt, beat, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/frame_mem_arbiter.sv
// Round-robin burst arbiter for a single-port frame memory with tagged read return.
// Define MEMARB_PERF_EN to add perf_cnt, three saturating per-requester beat counters.
//
// state | meaning
// IDLE  | no owner; round-robin pick among pending requests
// BURST | owner holds gnt; one beat per cycle while its req stays high
module frame_mem_arbiter #(
   parameter int RD_LAT = 1,
   parameter int AW     = 16,
   parameter int DW     = 24
) (
   input  logic                 CLK,
   input  logic                 reset,
   frame_mem_arbiter_if.slave   bus
`ifdef MEMARB_PERF_EN
   ,
   output logic [47:0]          perf_cnt
`endif
);

   typedef enum logic {IDLE, BURST} state_t;

   state_t     state, state_nx;
   logic [1:0] owner, owner_nx;
   logic [1:0] rr_ptr, rr_ptr_nx;
   logic [4:0] remaining, remaining_nx;
   logic [1:0] pick;
   logic       pick_vld;
   logic [4:0] len_sel;
   logic [2:0] owner_oh;
   logic [2:0] tag_pipe [RD_LAT];

   function automatic logic [1:0] wrap3(input logic [2:0] v);
      return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
   endfunction

   // Scan from the far end so the lowest offset from rr_ptr wins.
   always_comb begin
      pick     = 2'd0;
      pick_vld = 1'b0;
      for (int k = 2; k >= 0; k--) begin
         if (bus.req[wrap3({1'b0, rr_ptr} + 3'(k))]) begin
            pick     = wrap3({1'b0, rr_ptr} + 3'(k));
            pick_vld = 1'b1;
         end
      end
   end

   assign len_sel  = bus.len[5*pick +: 5];
   assign owner_oh = (state == BURST) ? (3'b001 << owner) : 3'b000;

   assign bus.gnt       = owner_oh;
   assign bus.beat      = owner_oh & bus.req;
   assign bus.mem_en    = |bus.beat;
   assign bus.mem_we    = bus.mem_en & bus.wr[owner];
   assign bus.mem_addr  = bus.addr[AW*owner +: AW];
   assign bus.mem_wdata = bus.wdata[DW*owner +: DW];

   always_comb begin
      state_nx     = state;
      owner_nx     = owner;
      rr_ptr_nx    = rr_ptr;
      remaining_nx = remaining;
      case (state)
         IDLE: begin
            if (pick_vld) begin
               owner_nx     = pick;
               rr_ptr_nx    = wrap3({1'b0, pick} + 3'd1);
               remaining_nx = (len_sel == 5'd0) ? 5'd1 : len_sel;
               state_nx     = BURST;
            end
         end
         BURST: begin
            if (bus.mem_en) begin
               remaining_nx = remaining - 5'd1;
               if (remaining == 5'd1) state_nx = IDLE;
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state     <= IDLE;
         owner     <= 2'd0;
         rr_ptr    <= 2'd0;
         remaining <= 5'd0;
      end else begin
         state     <= state_nx;
         owner     <= owner_nx;
         rr_ptr    <= rr_ptr_nx;
         remaining <= remaining_nx;
      end
   end

   // The tag travels alongside the memory read so returns follow the issuer, not the current owner.
   always_ff @(posedge CLK) begin
      if (reset) begin
         for (int k = 0; k < RD_LAT; k++) tag_pipe[k] <= 3'b000;
      end else begin
         tag_pipe[0] <= bus.beat & ~bus.wr;
         for (int k = 1; k < RD_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
      end
   end

   assign bus.rvalid = tag_pipe[RD_LAT-1];
   assign bus.rdata  = bus.mem_rdata;

`ifdef MEMARB_PERF_EN
   logic [15:0] perf_c [3];

   always_ff @(posedge CLK) begin
      if (reset) begin
         for (int k = 0; k < 3; k++) perf_c[k] <= 16'd0;
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (bus.beat[k] && perf_c[k] != 16'hFFFF) perf_c[k] <= perf_c[k] + 16'd1;
         end
      end
   end

   assign perf_cnt = {perf_c[2], perf_c[1], perf_c[0]};
`endif

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Scoreboard bench for frame_mem_arbiter: reads are queued with their expected destination and
// data when the beat is issued, and checked when rvalid returns.
module tb_frame_mem_arbiter;
   localparam int RD_LAT = 2;
   localparam int AW     = 16;
   localparam int DW     = 24;

   typedef struct packed {
      logic [2:0]  dest;
      logic [23:0] data;
   } sb_entry_t;

   logic CLK = 1'b0;
   logic reset = 1'b1;
   always #5 CLK = ~CLK;

   frame_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
`ifdef MEMARB_PERF_EN
   logic [47:0] perf_cnt;
`endif

   frame_mem_arbiter #(.RD_LAT(RD_LAT), .AW(AW), .DW(DW)) dut (
      .CLK   (CLK),
      .reset (reset),
      .bus   (bus)
`ifdef MEMARB_PERF_EN
      ,
      .perf_cnt (perf_cnt)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;
   sb_entry_t sb [$];
   logic [2:0] gl [$];
   logic [2:0] rl [$];
   logic       el [$];

   // requester models
   bit         rq     [3];
   int         base   [3];
   int         cnt    [3];
   int         stop_n [3];
   bit         hold   [3];
   bit         is_wr  [3];
   logic [4:0] lenv   [3];

   // memory model and independent shadow of expected contents
   bit [23:0]  mm [256];
   bit         mw [256];
   bit [23:0]  em [256];
   bit         ew [256];
   logic [23:0] rd_pipe [RD_LAT];

   function automatic logic [23:0] init_pat(input int a);
      return 24'hA50000 | 24'(a & 255);
   endfunction

   function automatic logic [23:0] wval(input int a);
      logic [23:0] t;
      t = 24'(a);
      return 24'h112233 + t * 24'h010101;
   endfunction

   always @(posedge CLK) begin
      if (bus.mem_en && bus.mem_we) begin
         mm[bus.mem_addr[7:0]] <= bus.mem_wdata;
         mw[bus.mem_addr[7:0]] <= 1'b1;
      end
      rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ?
                    (mw[bus.mem_addr[7:0]] ? mm[bus.mem_addr[7:0]] : init_pat(int'(bus.mem_addr[7:0]))) : 24'h0;
      for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
   end
   assign bus.mem_rdata = rd_pipe[RD_LAT-1];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive();
      int a;
      for (int i = 0; i < 3; i++) begin
         a = base[i] + cnt[i];
         bus.req[i]              = rq[i];
         bus.len[i*5 +: 5]       = lenv[i];
         bus.addr[i*AW +: AW]    = 16'(a);
         bus.wr[i]               = is_wr[i];
         bus.wdata[i*DW +: DW]   = wval(a);
      end
   endtask

   task automatic setup(input int i, input bit r, input int b, input logic [4:0] l,
                        input int stp, input bit w, input bit h);
      rq[i] = r; base[i] = b; lenv[i] = l; stop_n[i] = stp; is_wr[i] = w; hold[i] = h; cnt[i] = 0;
   endtask

   task automatic clear_logs();
      gl.delete(); rl.delete(); el.delete();
   endtask

   task automatic cycle();
      logic [2:0] g, b, rv;
      sb_entry_t  e;
      int         a;
      @(negedge CLK);
      g = bus.gnt; b = bus.beat; rv = bus.rvalid;
      gl.push_back(g); rl.push_back(rv); el.push_back(bus.mem_en);
      chk("mem_en_vs_beat", 64'(bus.mem_en), 64'(|b));
      for (int i = 0; i < 3; i++) begin
         if (b[i]) begin
            a = (base[i] + cnt[i]) & 255;
            chk("mem_addr", 64'(bus.mem_addr), 64'(a));
            chk("mem_we", 64'(bus.mem_we), 64'(is_wr[i]));
            if (is_wr[i]) begin
               chk("mem_wdata", 64'(bus.mem_wdata), 64'(wval(a)));
               em[a] = wval(a); ew[a] = 1'b1;
            end else begin
               e.dest = 3'b001 << i;
               e.data = ew[a] ? em[a] : init_pat(a);
               sb.push_back(e);
            end
         end
      end
      if (rv != 3'b000) begin
         if (sb.size() == 0) begin
            chk("rv_spurious", 64'(rv), 64'(0));
         end else begin
            e = sb.pop_front();
            chk("rv_dest", 64'(rv), 64'(e.dest));
            chk("rdata", 64'(bus.rdata), 64'(e.data));
         end
      end
      @(posedge CLK); #1;
      for (int i = 0; i < 3; i++) begin
         if (b[i]) begin
            cnt[i]++;
            if (cnt[i] == stop_n[i]) begin
               if (hold[i]) cnt[i] = 0;
               else rq[i] = 1'b0;
            end
         end
      end
      drive();
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 12 && sb.size() != 0; k++) cycle();
      chk(tag, 64'(sb.size()), 64'(0));
   endtask

   function automatic int first_idx(input bit rv_log, input int bitn);
      for (int k = 0; k < gl.size(); k++) begin
         if (rv_log ? rl[k][bitn] : gl[k][bitn]) return k;
      end
      return -1;
   endfunction

   function automatic int cnt_bits(input bit rv_log, input int bitn, input int from);
      int n = 0;
      for (int k = from; k < gl.size(); k++) n += int'(rv_log ? rl[k][bitn] : gl[k][bitn]);
      return n;
   endfunction

   initial begin
      int n;
      for (int i = 0; i < 3; i++) setup(i, 1'b0, 0, 5'd0, 1, 1'b0, 1'b0);
      drive();
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_gnt", 64'(bus.gnt), 64'(0));
      chk("rst_beat", 64'(bus.beat), 64'(0));
      chk("rst_rvalid", 64'(bus.rvalid), 64'(0));
      chk("rst_mem_en", 64'(bus.mem_en), 64'(0));
      chk("rst_mem_we", 64'(bus.mem_we), 64'(0));
`ifdef MEMARB_PERF_EN
      chk("rst_perf", 64'(perf_cnt), 64'(0));
`endif
      reset = 1'b0;

      // single 16-beat read burst from requester 1
      setup(1, 1'b1, 0, 5'd16, 16, 1'b0, 1'b0);
      drive(); clear_logs();
      repeat (20) cycle();
      chk("a_first_gnt", 64'(first_idx(1'b0, 1)), 64'(1));
      chk("a_gnt_cycles", 64'(cnt_bits(1'b0, 1, 0)), 64'(16));
      chk("a_gnt_drop", 64'(gl[17]), 64'(0));
      chk("a_first_rv", 64'(first_idx(1'b1, 1)), 64'(1 + RD_LAT));
      chk("a_rv_cycles", 64'(cnt_bits(1'b1, 1, 0)), 64'(16));
      drain("a_drain");

      // all three held high from reset, 3-beat bursts
      reset = 1'b1;
      for (int i = 0; i < 3; i++) setup(i, 1'b1, 16*i, 5'd3, 3, 1'b0, 1'b1);
      drive();
      repeat (2) @(posedge CLK);
      #1;
      sb.delete();
      reset = 1'b0; clear_logs();
      repeat (16) cycle();
      for (int c = 0; c < 16; c++) begin
         chk("b_gnt_seq", 64'(gl[c]), 64'((c % 4 == 0) ? 0 : (1 << ((c / 4) % 3))));
      end
`ifdef MEMARB_PERF_EN
      chk("b_perf", 64'(perf_cnt), {16'h0, 16'd3, 16'd3, 16'd6});
`endif
      for (int i = 0; i < 3; i++) rq[i] = 1'b0;
      drive();
      drain("b_drain");

      // requester 2 writes, then requester 1 reads the same words back
      clear_logs();
      setup(2, 1'b1, 8'h40, 5'd4, 4, 1'b1, 1'b0);
      drive();
      repeat (8) cycle();
      setup(1, 1'b1, 8'h40, 5'd4, 4, 1'b0, 1'b0);
      drive();
      repeat (8) cycle();
      drain("c_drain");
      chk("c_no_rv2", 64'(cnt_bits(1'b1, 2, 0)), 64'(0));
      chk("c_rv1", 64'(cnt_bits(1'b1, 1, 0)), 64'(4));
      chk("c_gnt2", 64'(cnt_bits(1'b0, 2, 0)), 64'(4));

      // read returns keep landing on requester 1 after requester 2 takes over
      clear_logs();
      setup(1, 1'b1, 8'h40, 5'd4, 4, 1'b0, 1'b0);
      drive();
      cycle();
      setup(2, 1'b1, 8'h80, 5'd2, 2, 1'b0, 1'b0);
      drive();
      repeat (11) cycle();
      n = first_idx(1'b0, 2);
      chk("d_first_gnt2", 64'(n), 64'(6));
      chk("d_rv1_at_gnt2", 64'(rl[6][1]), 64'(1));
      n = 0;
      for (int k = 1; k < gl.size(); k++) n += int'(rl[k][1] & ~gl[k][1]);
      chk("d_rv1_after_own", 64'(n), 64'(RD_LAT));
      n = 0;
      for (int k = 0; k < gl.size(); k++) n += int'(rl[k][1] & gl[k][2]);
      chk("d_rv1_overlap", 64'(n), 64'(RD_LAT - 1));
      chk("d_rv1", 64'(cnt_bits(1'b1, 1, 0)), 64'(4));
      drain("d_drain");

      // requester 0 abandons its 8-beat write after 2 beats; requester 1 waiting
      clear_logs();
      setup(0, 1'b1, 8'h90, 5'd8, 2, 1'b1, 1'b0);
      setup(1, 1'b1, 0, 5'd1, 1, 1'b0, 1'b0);
      drive();
      repeat (10) cycle();
      n = 0;
      for (int k = 0; k < gl.size(); k++) n += int'(el[k] & gl[k][0]);
      chk("e_mem_en", 64'(n), 64'(2));
      chk("e_gnt0", 64'(cnt_bits(1'b0, 0, 0)), 64'(3));
      chk("e_gnt0_clear", 64'(gl[4]), 64'(0));
      chk("e_first_gnt1", 64'(first_idx(1'b0, 1)), 64'(5));
      drain("e_drain");

      // reset in the middle of a read burst
      clear_logs();
      setup(1, 1'b1, 0, 5'd8, 8, 1'b0, 1'b0);
      drive();
      repeat (4) cycle();
      reset = 1'b1;
      cycle();
      sb.delete();
      cycle();
      chk("f_gnt", 64'(gl[5]), 64'(0));
      chk("f_mem_en", 64'(el[5]), 64'(0));
      chk("f_rvalid", 64'(rl[5]), 64'(0));
`ifdef MEMARB_PERF_EN
      chk("f_perf", 64'(perf_cnt), 64'(0));
`endif
      for (int i = 0; i < 3; i++) rq[i] = 1'b0;
      drive();
      reset = 1'b0;
      repeat (8) cycle();
      chk("f_no_rv_after", 64'(cnt_bits(1'b1, 1, 5)), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
